t05_char_rx: RTL and testbench
==============================

T05_CHAR_RX -- requirements
Module: t05_char_rx

Interface
REQ-001 SHALL have port: hwclk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: nrst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: pulse_in  input  1  byte-available strobe from host side; may be asynchronous to hwclk.
REQ-004 SHALL have port: read_out  input  8  host byte; stable while pulse_in high.
REQ-005 SHALL have port: nextChar  output  1  high = ready to accept next host byte.
REQ-006 SHALL have port: spi_confirm_out  output  1  byte-captured acknowledge to host.
REQ-007 SHALL have port: char_out  output  8  FIFO head byte to histogram stage.
REQ-008 SHALL have port: char_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port: char_ready  input  1  histogram stage consumes head when high with char_valid.
REQ-010 SHALL have port: eof_out  output  1  terminator seen and FIFO drained.
REQ-011 SHALL have port: fifo_count  output  3  occupancy, 0..4.

Function
REQ-012 SHALL pass pulse_in through a 2-flop synchronizer; pulse_s denotes the second flop output.
REQ-013 SHALL implement FSM states IDLE, CONFIRM, WAIT_LOW, DONE.
REQ-014 IDLE: when pulse_s=1 and fifo_count<4, SHALL capture read_out in that cycle and go to CONFIRM; if FIFO is full, SHALL remain in IDLE until space exists (no byte lost).
REQ-015 Captured byte != 8'h1A SHALL be pushed to FIFO; 8'h1A SHALL NOT be pushed and SHALL set eof_seen.
REQ-016 CONFIRM: spi_confirm_out=1 and held; SHALL advance to WAIT_LOW next cycle.
REQ-017 WAIT_LOW: spi_confirm_out=1 until pulse_s=0, then spi_confirm_out=0 and next state is DONE if eof_seen, else IDLE.
REQ-018 nextChar SHALL equal (state==IDLE && fifo_count<4 && !eof_seen), registered-state combinational.
REQ-019 DONE: SHALL ignore pulse_in; spi_confirm_out=0, nextChar=0; exit only by reset.
REQ-020 FIFO: 4 entries, 2-bit wrapping pointers; char_out = head; char_valid = (fifo_count!=0).
REQ-021 Pop when char_valid && char_ready; push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-022 Pop on empty and push on full SHALL never occur (guarded internally).
REQ-023 eof_out SHALL be 1 when eof_seen && fifo_count==0, held until reset.
REQ-024 Capture-to-spi_confirm_out latency SHALL be 1 cycle; pulse_in rise to capture SHALL be 2-3 cycles.

Reset
REQ-025 When nrst=0 at a clock edge: state=IDLE, FIFO empty, pointers 0, eof_seen=0, synchronizer flops 0, spi_confirm_out=0, char_valid=0, eof_out=0, fifo_count=0.
REQ-026 Reset asserted mid-handshake (CONFIRM/WAIT_LOW/DONE) SHALL abort it; after release, a still-high pulse_in SHALL be treated as a new byte.
REQ-027 nextChar SHALL read 1 in the first cycle after reset release.

Configuration
REQ-028 Macro T05_CHAR_COUNT_EN defined: SHALL add port char_count  output  24  number of bytes pushed (terminator excluded), saturating at 24'hFFFFFF, cleared by reset.
REQ-029 Macro T05_CHAR_COUNT_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, pulse_in=1 with read_out=8'h12, char_ready=0 -> spi_confirm_out rises within 4 cycles, nextChar=0; after pulse_in=0, spi_confirm_out falls, nextChar=1, char_out=8'h12, fifo_count=1.
REQ-031 Five bytes 8'h12,8'h12,8'h12,8'h1F,8'h1F with char_ready=0 -> fifo_count=4 after fourth, nextChar=0, fifth held without confirm; char_ready=1 for one cycle -> fifth captured, order 12,12,12,1F,1F on char_out.
REQ-032 char_ready=1 permanently, bytes 8'h31,8'h12 -> each byte presented one cycle after push, fifo_count never exceeds 1, concurrent push/pop leaves count unchanged.
REQ-033 Byte 8'h12 then 8'h1A, char_ready=0 -> 8'h1A confirmed but not pushed, state DONE, nextChar=0, eof_out=0; char_ready=1 -> after pop eof_out=1; further pulse_in gets no confirm.
REQ-034 nrst=0 during WAIT_LOW with 2 bytes queued -> fifo_count=0, spi_confirm_out=0, eof_out=0; with T05_CHAR_COUNT_EN, char_count=0 after reset and =2 before it.

Source files
------------

// File: rtl/t05_char_rx.sv
`default_nettype none
// ============================================================================
// Module      : t05_char_rx
// Description : Host byte receiver. Synchronises the host strobe, captures
//               each byte through a four-phase confirm handshake and queues
//               it in a 4-entry FIFO for the histogram stage. Byte 8'h1A is
//               the end-of-file terminator: it is acknowledged but not queued,
//               and it parks the receiver until reset.
//               Optional feature macro: T05_CHAR_COUNT_EN adds a saturating
//               24-bit count of queued bytes on port char_count.
// Revision    : 1.0 - initial release
// ============================================================================
module t05_char_rx (
    input  logic        hwclk,
    input  logic        nrst,
    input  logic        pulse_in,
    input  logic [7:0]  read_out,
    output logic        nextChar,
    output logic        spi_confirm_out,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        eof_out,
    output logic [2:0]  fifo_count
`ifdef T05_CHAR_COUNT_EN
    ,
    output logic [23:0] char_count
`endif
);

    localparam logic [7:0] c_EOF_CHAR   = 8'h1A;
    localparam logic [2:0] c_FIFO_DEPTH = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        WAIT_LOW = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_confirm;
    logic        r_eof_seen;
    logic [7:0]  r_mem [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_has_space;
    logic        w_capture;
    logic        w_push;
    logic        w_pop;

    // Capture happens only from IDLE with a synchronised strobe and room in
    // the FIFO; a full FIFO simply stalls the handshake so no byte is lost.
    assign w_has_space = (r_count < c_FIFO_DEPTH);
    assign w_capture   = (r_state == IDLE) && r_sync2 && w_has_space && !r_eof_seen;
    assign w_push      = w_capture && (read_out != c_EOF_CHAR);
    assign w_pop       = (r_count != 3'd0) && char_ready;

    assign nextChar        = (r_state == IDLE) && w_has_space && !r_eof_seen;
    assign spi_confirm_out = r_confirm;
    assign char_out        = r_mem[r_rd_ptr];
    assign char_valid      = (r_count != 3'd0);
    assign eof_out         = r_eof_seen && (r_count == 3'd0);
    assign fifo_count      = r_count;

    // Two-flop synchroniser for the asynchronous host strobe
    always_ff @(posedge hwclk) begin
        if (!nrst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
        end
    end

    // Handshake FSM: confirm is registered so it follows capture by one cycle
    always_ff @(posedge hwclk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_confirm  <= 1'b0;
            r_eof_seen <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_confirm <= 1'b0;
                    if (w_capture) begin
                        r_state   <= CONFIRM;
                        r_confirm <= 1'b1;
                        if (read_out == c_EOF_CHAR) begin
                            r_eof_seen <= 1'b1;
                        end
                    end
                end
                CONFIRM: begin
                    r_state   <= WAIT_LOW;
                    r_confirm <= 1'b1;
                end
                WAIT_LOW: begin
                    if (!r_sync2) begin
                        r_confirm <= 1'b0;
                        r_state   <= r_eof_seen ? DONE : IDLE;
                    end
                end
                DONE: begin
                    r_confirm <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_confirm <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage, wrapping pointers and occupancy; push/pop guarded above
    always_ff @(posedge hwclk) begin
        if (!nrst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= read_out;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef T05_CHAR_COUNT_EN
    logic [23:0] r_char_count;

    assign char_count = r_char_count;

    // Saturating count of bytes queued; the terminator is never pushed
    always_ff @(posedge hwclk) begin
        if (!nrst) begin
            r_char_count <= 24'd0;
        end else if (w_push && (r_char_count != 24'hFFFFFF)) begin
            r_char_count <= r_char_count + 24'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_t05_char_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_t05_char_rx
// Description : Directed self-checking bench for t05_char_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t05_char_rx;

    logic        hwclk = 1'b0;
    logic        nrst = 1'b0;
    logic        pulse_in = 1'b0;
    logic [7:0]  read_out = 8'h00;
    logic        nextChar;
    logic        spi_confirm_out;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready = 1'b0;
    logic        eof_out;
    logic [2:0]  fifo_count;
`ifdef T05_CHAR_COUNT_EN
    logic [23:0] char_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int max_cnt = 0;

    always #5 hwclk = ~hwclk;

    t05_char_rx dut (
        .hwclk           (hwclk),
        .nrst            (nrst),
        .pulse_in        (pulse_in),
        .read_out        (read_out),
        .nextChar        (nextChar),
        .spi_confirm_out (spi_confirm_out),
        .char_out        (char_out),
        .char_valid      (char_valid),
        .char_ready      (char_ready),
        .eof_out         (eof_out),
        .fifo_count      (fifo_count)
`ifdef T05_CHAR_COUNT_EN
        ,
        .char_count      (char_count)
`endif
    );

    // Hold reset over two rising edges; returns on the falling edge after release
    task automatic do_reset();
        @(negedge hwclk);
        nrst = 1'b0; pulse_in = 1'b0; char_ready = 1'b0; read_out = 8'h00;
        @(negedge hwclk);
        @(negedge hwclk);
        nrst = 1'b1;
    endtask

    // Full host handshake; reports the FIFO head seen when confirm first rises
    task automatic host_push(input logic [7:0] b, output bit ok,
                             output logic v, output logic [7:0] c);
        bit seen;
        seen = 1'b0; v = 1'b0; c = 8'h00;
        read_out = b; pulse_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (spi_confirm_out) begin
                seen = 1'b1; v = char_valid; c = char_out;
                break;
            end
        end
        pulse_in = 1'b0;
        ok = 1'b0;
        if (seen) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge hwclk);
                if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
                if (!spi_confirm_out) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (spi_confirm_out !== 1'b0) $display("FAIL reset_confirm got %b exp 0", spi_confirm_out); else n_pass++;
        n_total++; if (char_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", char_valid); else n_pass++;
        n_total++; if (eof_out !== 1'b0) $display("FAIL reset_eof got %b exp 0", eof_out); else n_pass++;
        n_total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else n_pass++;
        n_total++; if (nextChar !== 1'b1) $display("FAIL reset_nextchar got %b exp 1", nextChar); else n_pass++;
`ifdef T05_CHAR_COUNT_EN
        n_total++; if (char_count !== 24'd0) $display("FAIL reset_charcount got %0d exp 0", char_count); else n_pass++;
`endif
    endtask

    task automatic test_single();
        bit seen;
        bit fell;
        do_reset();
        read_out = 8'h12; pulse_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge hwclk);
            if (spi_confirm_out) begin seen = 1'b1; break; end
        end
        n_total++; if (seen !== 1'b1) $display("FAIL single_confirm_rise got %b exp 1", seen); else n_pass++;
        n_total++; if (nextChar !== 1'b0) $display("FAIL single_nextchar_busy got %b exp 0", nextChar); else n_pass++;
        pulse_in = 1'b0;
        fell = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (!spi_confirm_out) begin fell = 1'b1; break; end
        end
        n_total++; if (fell !== 1'b1) $display("FAIL single_confirm_fall got %b exp 1", fell); else n_pass++;
        n_total++; if (nextChar !== 1'b1) $display("FAIL single_nextchar got %b exp 1", nextChar); else n_pass++;
        n_total++; if (char_out !== 8'h12) $display("FAIL single_char got %h exp 12", char_out); else n_pass++;
        n_total++; if (fifo_count !== 3'd1) $display("FAIL single_count got %0d exp 1", fifo_count); else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0] bytes [4];
        logic [7:0] drain [4];
        bit ok;
        bit conf;
        logic v;
        logic [7:0] c;
        bytes = '{8'h12, 8'h12, 8'h12, 8'h1F};
        drain = '{8'h12, 8'h12, 8'h1F, 8'h1F};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            host_push(bytes[i], ok, v, c);
            n_total++; if (ok !== 1'b1) $display("FAIL full_push%0d handshake got %b exp 1", i, ok); else n_pass++;
        end
        n_total++; if (fifo_count !== 3'd4) $display("FAIL full_count got %0d exp 4", fifo_count); else n_pass++;
        n_total++; if (nextChar !== 1'b0) $display("FAIL full_nextchar got %b exp 0", nextChar); else n_pass++;
        // Fifth byte must stall without any confirm while full
        read_out = 8'h1F; pulse_in = 1'b1;
        conf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hwclk);
            if (spi_confirm_out) conf = 1'b1;
        end
        n_total++; if (conf !== 1'b0) $display("FAIL full_held_confirm got %b exp 0", conf); else n_pass++;
        n_total++; if (fifo_count !== 3'd4) $display("FAIL full_held_count got %0d exp 4", fifo_count); else n_pass++;
        n_total++; if (char_out !== 8'h12) $display("FAIL full_head got %h exp 12", char_out); else n_pass++;
        char_ready = 1'b1;
        @(negedge hwclk);
        char_ready = 1'b0;
        conf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (spi_confirm_out) begin conf = 1'b1; break; end
            @(negedge hwclk);
        end
        n_total++; if (conf !== 1'b1) $display("FAIL full_fifth_confirm got %b exp 1", conf); else n_pass++;
        pulse_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (!spi_confirm_out) break;
        end
        n_total++; if (fifo_count !== 3'd4) $display("FAIL full_refill_count got %0d exp 4", fifo_count); else n_pass++;
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (char_out !== drain[i]) $display("FAIL full_order%0d got %h exp %h", i, char_out, drain[i]); else n_pass++;
            @(negedge hwclk);
        end
        char_ready = 1'b0;
        n_total++; if (fifo_count !== 3'd0) $display("FAIL full_drained got %0d exp 0", fifo_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit fell;
        logic v;
        logic [7:0] c;
        do_reset();
        char_ready = 1'b1;
        max_cnt = 0;
        host_push(8'h31, ok, v, c);
        n_total++; if ({ok, v, c} !== {1'b1, 1'b1, 8'h31}) $display("FAIL b2b_first got ok=%b v=%b c=%h exp 1 1 31", ok, v, c); else n_pass++;
        host_push(8'h12, ok, v, c);
        n_total++; if ({ok, v, c} !== {1'b1, 1'b1, 8'h12}) $display("FAIL b2b_second got ok=%b v=%b c=%h exp 1 1 12", ok, v, c); else n_pass++;
        n_total++; if (max_cnt !== 1) $display("FAIL b2b_max_count got %0d exp 1", max_cnt); else n_pass++;
        // Line up a push with a pop in the same cycle
        char_ready = 1'b0;
        host_push(8'h41, ok, v, c);
        n_total++; if (fifo_count !== 3'd1) $display("FAIL b2b_preload got %0d exp 1", fifo_count); else n_pass++;
        read_out = 8'h42; pulse_in = 1'b1;
        @(negedge hwclk);
        @(negedge hwclk);
        char_ready = 1'b1;
        @(negedge hwclk);
        char_ready = 1'b0;
        n_total++; if (spi_confirm_out !== 1'b1) $display("FAIL b2b_conc_confirm got %b exp 1", spi_confirm_out); else n_pass++;
        n_total++; if (fifo_count !== 3'd1) $display("FAIL b2b_conc_count got %0d exp 1", fifo_count); else n_pass++;
        n_total++; if (char_out !== 8'h42) $display("FAIL b2b_conc_head got %h exp 42", char_out); else n_pass++;
        pulse_in = 1'b0;
        fell = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (!spi_confirm_out) begin fell = 1'b1; break; end
        end
        n_total++; if (fell !== 1'b1) $display("FAIL b2b_conc_release got %b exp 1", fell); else n_pass++;
    endtask

    task automatic test_eof();
        bit ok;
        bit conf;
        logic v;
        logic [7:0] c;
        do_reset();
        host_push(8'h12, ok, v, c);
        host_push(8'h1A, ok, v, c);
        n_total++; if (ok !== 1'b1) $display("FAIL eof_confirm got %b exp 1", ok); else n_pass++;
        n_total++; if (fifo_count !== 3'd1) $display("FAIL eof_not_pushed got %0d exp 1", fifo_count); else n_pass++;
        n_total++; if (nextChar !== 1'b0) $display("FAIL eof_nextchar got %b exp 0", nextChar); else n_pass++;
        n_total++; if (eof_out !== 1'b0) $display("FAIL eof_early got %b exp 0", eof_out); else n_pass++;
        char_ready = 1'b1;
        @(negedge hwclk);
        char_ready = 1'b0;
        n_total++; if (fifo_count !== 3'd0) $display("FAIL eof_drain got %0d exp 0", fifo_count); else n_pass++;
        n_total++; if (eof_out !== 1'b1) $display("FAIL eof_out got %b exp 1", eof_out); else n_pass++;
        read_out = 8'h55; pulse_in = 1'b1;
        conf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (spi_confirm_out) conf = 1'b1;
        end
        pulse_in = 1'b0;
        n_total++; if (conf !== 1'b0) $display("FAIL eof_ignore_confirm got %b exp 0", conf); else n_pass++;
        n_total++; if ({eof_out, nextChar, fifo_count} !== {1'b1, 1'b0, 3'd0}) $display("FAIL eof_hold got eof=%b next=%b cnt=%0d exp 1 0 0", eof_out, nextChar, fifo_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        logic v;
        logic [7:0] c;
        do_reset();
        host_push(8'h12, ok, v, c);
        read_out = 8'h34; pulse_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (spi_confirm_out) break;
        end
        @(negedge hwclk);
        n_total++; if ({spi_confirm_out, fifo_count} !== {1'b1, 3'd2}) $display("FAIL mid_before got conf=%b cnt=%0d exp 1 2", spi_confirm_out, fifo_count); else n_pass++;
`ifdef T05_CHAR_COUNT_EN
        n_total++; if (char_count !== 24'd2) $display("FAIL mid_charcount_before got %0d exp 2", char_count); else n_pass++;
`endif
        nrst = 1'b0;
        @(negedge hwclk);
        n_total++; if (fifo_count !== 3'd0) $display("FAIL mid_count got %0d exp 0", fifo_count); else n_pass++;
        n_total++; if ({spi_confirm_out, eof_out, char_valid} !== 3'b000) $display("FAIL mid_flags got %b%b%b exp 000", spi_confirm_out, eof_out, char_valid); else n_pass++;
`ifdef T05_CHAR_COUNT_EN
        n_total++; if (char_count !== 24'd0) $display("FAIL mid_charcount_after got %0d exp 0", char_count); else n_pass++;
`endif
        nrst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge hwclk);
            if (spi_confirm_out) begin seen = 1'b1; break; end
        end
        n_total++; if (seen !== 1'b1) $display("FAIL mid_recapture got %b exp 1", seen); else n_pass++;
        n_total++; if ({fifo_count, char_out} !== {3'd1, 8'h34}) $display("FAIL mid_new_byte got cnt=%0d c=%h exp 1 34", fifo_count, char_out); else n_pass++;
        pulse_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hwclk);
            if (!spi_confirm_out) break;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_eof();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
